// File: rtl/conv_accum.sv
// conv_accum: sums per-pixel conv products over n_ch input channels in a pixel
// buffer, adds bias, applies optional ReLU, rescales/saturates to SIZE bits and
// streams the results to feature memory.
//
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   start           begin one output map (sampled in IDLE only)
//   matrix2         pixels per map (clamped to DEPTH), latched on start
//   n_ch            channels to sum (0 -> 1, >16 -> 16), latched on start
//   relu_en, bias   ReLU enable and signed bias (SIZE-1 frac bits), latched on start
//   in_valid/in_data/in_ready   product stream, raster order, channel-major
//   out_valid/out_addr/out_data feature-memory write port (1-cycle latency)
//   busy, done      busy from accepted start until done; done is a 1-cycle pulse
module conv_accum #(
    parameter int unsigned SIZE  = 23,
    parameter int unsigned DEPTH = 784,
    parameter int unsigned ACC_W = 2 * SIZE + 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [9:0]            matrix2,
    input  logic [4:0]            n_ch,
    input  logic                  relu_en,
    input  logic [SIZE-1:0]       bias,
    input  logic                  in_valid,
    input  logic [2*SIZE-2:0]     in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [9:0]            out_addr,
    output logic [SIZE-1:0]       out_data,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned PW  = 2 * SIZE - 1;
    localparam int unsigned AW  = 10;
    localparam int unsigned CW  = 5;
    localparam int unsigned FRAC = SIZE - 1;
    localparam int unsigned HW  = ACC_W - FRAC;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [AW-1:0]     pix_q, pix_d;
    logic [CW-1:0]     ch_q, ch_d;
    logic [AW-1:0]     m2_q, m2_d;
    logic [CW-1:0]     nch_q, nch_d;
    logic              relu_q, relu_d;
    logic [SIZE-1:0]   bias_q, bias_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              out_valid_q, out_valid_d;
    logic [AW-1:0]     out_addr_q, out_addr_d;
    logic [SIZE-1:0]   out_data_q, out_data_d;

    logic signed [ACC_W-1:0] pix_buf [DEPTH];

    logic                    xfer;
    logic                    last_pix;
    logic                    last_ch;
    logic [AW-1:0]           m2_clamp;
    logic [CW-1:0]           nch_clamp;
    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] bias_sh;
    logic signed [ACC_W-1:0] prev;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] s_full;
    logic signed [ACC_W-1:0] s_sh;
    logic [HW-1:0]           s_hi;
    logic [SIZE-1:0]         res;
    logic                    buf_we;
    logic signed [ACC_W-1:0] buf_wd;

    // Datapath: accumulate, rescale, ReLU, saturate
    always_comb begin
        xfer      = in_valid && in_ready_q;
        last_pix  = (pix_q == m2_q - AW'(1));
        last_ch   = (ch_q == nch_q - CW'(1));
        x_ext     = {{(ACC_W-PW){in_data[PW-1]}}, in_data};
        bias_sh   = {{(ACC_W-SIZE){bias_q[SIZE-1]}}, bias_q} <<< FRAC;
        prev      = pix_buf[pix_q];
        // Single-channel maps never wrote the buffer, so ignore its stale contents.
        base      = (nch_q == CW'(1)) ? '0 : prev;
        s_full    = base + x_ext + bias_sh;
        s_sh      = s_full >>> FRAC;
        s_hi      = s_sh[ACC_W-1:FRAC];
        if (relu_q && s_sh[ACC_W-1]) begin
            res = '0;
        end else if ((&s_hi) || !(|s_hi)) begin
            res = s_sh[SIZE-1:0];
        end else if (s_sh[ACC_W-1]) begin
            res = {1'b1, {(SIZE-1){1'b0}}};
        end else begin
            res = {1'b0, {(SIZE-1){1'b1}}};
        end
        buf_we    = xfer && !last_ch;
        buf_wd    = (ch_q == '0) ? x_ext : (prev + x_ext);
        m2_clamp  = (matrix2 > AW'(DEPTH)) ? AW'(DEPTH) : matrix2;
        // Accumulator headroom covers 16 channels; out-of-range counts are pinned.
        if (n_ch == '0) begin
            nch_clamp = CW'(1);
        end else if (n_ch > CW'(16)) begin
            nch_clamp = CW'(16);
        end else begin
            nch_clamp = n_ch;
        end
    end

    // Next state and registered outputs
    always_comb begin
        state_d     = state_q;
        pix_d       = pix_q;
        ch_d        = ch_q;
        m2_d        = m2_q;
        nch_d       = nch_q;
        relu_d      = relu_q;
        bias_d      = bias_q;
        out_valid_d = 1'b0;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m2_d    = m2_clamp;
                    nch_d   = nch_clamp;
                    relu_d  = relu_en;
                    bias_d  = bias;
                    pix_d   = '0;
                    ch_d    = '0;
                    state_d = (m2_clamp == '0) ? S_FIN : S_ACC;
                end
            end
            S_ACC: begin
                if (xfer) begin
                    if (last_ch) begin
                        out_valid_d = 1'b1;
                        out_addr_d  = pix_q;
                        out_data_d  = res;
                    end
                    if (last_pix) begin
                        pix_d = '0;
                        if (last_ch) begin
                            state_d = S_FIN;
                        end else begin
                            ch_d = ch_q + CW'(1);
                        end
                    end else begin
                        pix_d = pix_q + AW'(1);
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_ACC);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_FIN);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pix_q       <= '0;
            ch_q        <= '0;
            m2_q        <= '0;
            nch_q       <= CW'(1);
            relu_q      <= 1'b0;
            bias_q      <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            pix_q       <= pix_d;
            ch_q        <= ch_d;
            m2_q        <= m2_d;
            nch_q       <= nch_d;
            relu_q      <= relu_d;
            bias_q      <= bias_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
        end
    end

    // Partial-sum buffer; contents need no reset since channel 0 overwrites them
    always_ff @(posedge clk) begin
        if (buf_we) begin
            pix_buf[pix_q] <= buf_wd;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
